// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter sharing one UART frame transmitter among NUM_REQ sources.
// Optional `UART_ARB_TAG_EN replaces the top data byte with the grant index.
module uart_frame_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [NUM_REQ-1:0]            o_done,
  output logic                          o_busy,
  output logic                          o_tx_request,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  input  logic                          i_tx_busy,
  input  logic                          i_tx_done
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t                 state_reg;
  logic [IDX_W-1:0]       grant_reg;
  logic [IDX_W-1:0]       last_grant_reg;
  logic [IDX_W-1:0]       pick;
  logic                   pick_valid;
  logic [DATA_WIDTH-1:0]  req_word [NUM_REQ];
  logic [DATA_WIDTH-1:0]  frame_word;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_word[gi] = i_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest requester after
  // last_grant_reg is the one that sticks.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (i_req[(int'(last_grant_reg) + off) % NUM_REQ]) begin
        pick       = IDX_W'((int'(last_grant_reg) + off) % NUM_REQ);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
`ifdef UART_ARB_TAG_EN
    frame_word = {8'(pick), req_word[pick][DATA_WIDTH-9:0]};
`else
    frame_word = req_word[pick];
`endif
  end

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
      o_ack          <= '0;
      o_done         <= '0;
      o_busy         <= 1'b0;
      o_tx_request   <= 1'b0;
      o_tx_data      <= '0;
    end else begin
      o_ack        <= '0;
      o_done       <= '0;
      o_tx_request <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_valid && !i_tx_busy) begin
            o_tx_data <= frame_word;
            o_ack     <= onehot(pick);
            grant_reg <= pick;
            o_busy    <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          o_tx_request <= 1'b1;
          state_reg    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // Priority rotates only once the frame has actually gone out.
          if (i_tx_done) begin
            o_done         <= onehot(grant_reg);
            last_grant_reg <= grant_reg;
            o_busy         <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: begin
          o_busy    <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Self-checking bench for uart_frame_arbiter: requester and transmitter models,
// expected grants queued at stimulus time and compared as acks appear.
module tb_uart_frame_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 64;
  localparam int FRAME = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req;
  logic [NR-1:0] ack;
  logic [NR-1:0] done;
  logic          busy;
  logic          tx_req;
  logic [DW-1:0] tx_data;
  logic [NR*DW-1:0] data_bus;
  logic          model_busy = 1'b0;
  logic          model_done = 1'b0;
  logic          hold_busy  = 1'b0;
  logic          extra_done = 1'b0;
  logic          tx_busy_in;
  logic          tx_done_in;

  logic [DW-1:0] words [NR];
  int            want [NR];
  int            got  [NR];
  int            exp_q [$];
  int            rd_idx = 0;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int ack_cycle = 0;
  int cur_grant = 0;
  int mon_g = 0;
  int ack_count = 0;
  int done_count = 0;
  int txreq_count = 0;
  int frame_cnt = 0;
  bit done_pending = 1'b0;

  always #10 clk = ~clk;

  assign data_bus   = {words[3], words[2], words[1], words[0]};
  assign tx_busy_in = model_busy | hold_busy;
  assign tx_done_in = model_done | extra_done;

  always_comb begin
    req = '0;
    for (int k = 0; k < NR; k++) req[k] = (want[k] > got[k]);
  end

  uart_frame_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_req        (req),
    .i_data       (data_bus),
    .o_ack        (ack),
    .o_done       (done),
    .o_busy       (busy),
    .o_tx_request (tx_req),
    .o_tx_data    (tx_data),
    .i_tx_busy    (tx_busy_in),
    .i_tx_done    (tx_done_in)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] onehot(input int g);
    logic [DW-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_word(input int g);
`ifdef UART_ARB_TAG_EN
    return {8'(g), words[g][DW-9:0]};
`else
    return words[g];
`endif
  endfunction

  // Transmitter model: busy for FRAME cycles after a request, then one done pulse.
  always @(negedge clk) begin
    if (rst) begin
      model_busy = 1'b0;
      model_done = 1'b0;
      frame_cnt  = 0;
    end else begin
      model_done = 1'b0;
      if (tx_req) begin
        model_busy = 1'b1;
        frame_cnt  = FRAME;
      end else if (frame_cnt > 0) begin
        frame_cnt--;
        if (frame_cnt == 0) begin
          model_busy = 1'b0;
          model_done = 1'b1;
        end
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      done_pending = 1'b0;
    end else begin
      if (done != '0) begin
        check("done_vec", 64'(done), onehot(cur_grant));
        check("done_pending", 64'(done_pending), 64'd1);
        done_pending = 1'b0;
        done_count++;
        $display("done  grant=%0d cycle=%0d", cur_grant, cycle);
      end
      if (ack != '0) begin
        ack_count++;
        for (int k = 0; k < NR; k++) if (ack[k]) got[k]++;
        if (rd_idx < exp_q.size()) begin
          mon_g = exp_q[rd_idx];
          rd_idx++;
          check("ack_vec", 64'(ack), onehot(mon_g));
          check("tx_data", tx_data, exp_word(mon_g));
          check("busy_on_ack", 64'(busy), 64'd1);
          cur_grant = mon_g;
        end else begin
          check("ack_unexpected", 64'(ack), 64'd0);
        end
        ack_cycle    = cycle;
        done_pending = 1'b1;
        $display("ack   vec=%b data=%h cycle=%0d", ack, tx_data, cycle);
      end
      if (tx_req) begin
        txreq_count++;
        check("txreq_latency", 64'(cycle - ack_cycle), 64'd1);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((rd_idx < exp_q.size() || done_pending || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(n < budget), 64'd1);
    @(negedge clk);
  endtask

  logic [NR-1:0] acc;
  int            n_wait;

  initial begin
    words[0] = 64'hA0A1A2A3A4A5A6A7;
    words[1] = 64'hB0B1B2B3B4B5B6B7;
    words[2] = 64'h1122334455667788;
`ifdef UART_ARB_TAG_EN
    words[3] = 64'hFFFFFFFFFFFFFFFF;
`else
    words[3] = 64'hD0D1D2D3D4D5D6D7;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_txreq", 64'(tx_req), 64'd0);
    check("rst_txdata", tx_data, 64'd0);
    rst = 1'b0;

    // Single request from requester 2
    want[2]++;
    exp_q.push_back(2);
    @(negedge clk);
    check("t1_ack", 64'(ack), 64'h4);
    check("t1_data", tx_data, exp_word(2));
    check("t1_txreq_n1", 64'(tx_req), 64'd0);
    @(negedge clk);
    check("t1_txreq_n2", 64'(tx_req), 64'd1);
    @(negedge clk);
    check("t1_txreq_n3", 64'(tx_req), 64'd0);
    wait_idle(200);
    check("t1_done_cnt", 64'(done_count), 64'd1);

    // All four requesting from reset: 0,1,2,3,0
    do_reset();
    want[0] += 2;
    want[1]++;
    want[2]++;
    want[3]++;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    wait_idle(1000);
    check("t2_txreq_vs_done", 64'(txreq_count), 64'(done_count));

    // Requester 0 held while requester 2 competes: 0,2,0,2
    do_reset();
    want[0] += 2;
    want[2] += 2;
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(2);
    wait_idle(1000);

    // Transmitter busy hold for 100 cycles
    hold_busy = 1'b1;
    want[0]++;
    exp_q.push_back(0);
    acc = '0;
    repeat (100) begin
      @(negedge clk);
      acc |= ack;
    end
    check("t4_no_ack_hold", 64'(acc), 64'd0);
    hold_busy = 1'b0;
    @(negedge clk);
    check("t4_ack_after_release", 64'(ack), 64'h1);
    wait_idle(200);

    // Reset in WAIT_DONE abandons the frame
    do_reset();
    want[0]++;
    exp_q.push_back(0);
    wait_idle(200);
    want[2]++;
    exp_q.push_back(2);
    n_wait = 0;
    while (!tx_req && n_wait < 50) begin
      @(negedge clk);
      n_wait++;
    end
    check("t5_txreq_seen", 64'(n_wait < 50), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_ack", 64'(ack), 64'd0);
    check("t5_rst_done", 64'(done), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_txreq", 64'(tx_req), 64'd0);
    check("t5_rst_txdata", tx_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    extra_done = 1'b1;
    @(negedge clk);
    extra_done = 1'b0;
    acc = '0;
    repeat (5) begin
      @(negedge clk);
      acc |= done;
    end
    check("t5_no_done", 64'(acc), 64'd0);
    check("t5_idle_busy", 64'(busy), 64'd0);
    want[0]++;
    want[1]++;
    exp_q.push_back(0);
    exp_q.push_back(1);
    wait_idle(500);

    check("ack_total", 64'(ack_count), 64'd15);
    check("txreq_total", 64'(txreq_count), 64'd15);
    check("done_total", 64'(done_count), 64'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_arbiter.md
# uart_frame_arbiter

Round-robin arbiter that shares one `UartTransmitFrame` instance among several frame sources (status counters, debug dumps, command responses). It sits between the requesters and the transmitter: it captures one requester's data word, issues a single-cycle transmit request, waits for the frame to complete, and then rotates priority. It replaces the hard-wired single-source request/data hookup to the transmitter.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..16).
- `DATA_WIDTH`, default 64: frame data width; it must match the transmitter.
- `i_clock` in 1: system clock, 50 MHz nominal.
- `i_reset` in 1: reset; one clock; reset is asynchronous and active-high.
- `i_req` in NUM_REQ: level request per requester, held until its `o_ack` bit.
- `i_data` in NUM_REQ*DATA_WIDTH: requester k data in bits [k*DATA_WIDTH +: DATA_WIDTH]; must be stable while `i_req[k]` is high.
- `o_ack` out NUM_REQ: one-cycle pulse; the requester's data has been captured.
- `o_done` out NUM_REQ: one-cycle pulse; the granted requester's frame has finished transmitting.
- `o_busy` out 1: high whenever the state is not IDLE.
- `o_tx_request` out 1: one-cycle request to the transmitter (`i_request`).
- `o_tx_data` out DATA_WIDTH: latched frame data to the transmitter (`i_data`).
- `i_tx_busy` in 1: transmitter `o_busy`.
- `i_tx_done` in 1: transmitter `o_done` pulse.

## Operation
- The state machine has three states: IDLE, ISSUE, WAIT_DONE.
- IDLE: if any `i_req` bit is high and `i_tx_busy` is low, the arbiter:
  - selects grant g as the first set bit searching upward from `last_grant+1`, wrapping modulo NUM_REQ;
  - latches `i_data` slice g into `o_tx_data`;
  - pulses `o_ack[g]`, stores g, and goes to ISSUE.
- ISSUE: pulses `o_tx_request` and goes to WAIT_DONE unconditionally.
- WAIT_DONE: on `i_tx_done`, pulses `o_done[g]`, sets `last_grant <= g`, and goes to IDLE.
- `i_tx_done` is ignored in IDLE and ISSUE.
- `i_tx_busy` high in IDLE blocks all grants. Requests stay pending and are not acknowledged.
- A request withdrawn before the grant edge is never granted. No data is captured for it.
- Simultaneous requests: exactly one grant per frame, in rotating priority. Starvation is bounded by NUM_REQ-1 frames.
- `o_tx_data` holds its value from capture until the next capture. It is never cleared outside reset.
- Reset:
  - all outputs are 0, the state is IDLE, and `last_grant = NUM_REQ-1`, so requester 0 wins first;
  - asserting reset mid-frame abandons the frame: no `o_done` is issued for it, and the requester must re-request.

## Timing
- All outputs are registered.
- Request seen at edge N (IDLE, not blocked):
  - `o_ack[g]` and `o_busy` are high in cycle N+1;
  - `o_tx_request` is high in cycle N+2 only;
  - `o_tx_data` is valid from cycle N+1.
- `i_tx_done` sampled at edge D: `o_done[g]` is high in cycle D+1, and the state is IDLE in cycle D+1.
- The next grant is sampled at edge D+1, so `o_ack` for the next frame appears in cycle D+2.
- Minimum gap from one `o_tx_request` to the next is the frame time plus 3 cycles.
- `o_ack` and `o_done` are never both high for the same requester in the same cycle. Otherwise the two pulse vectors are independent.

## Configuration
- `UART_ARB_TAG_EN`:
  - Defined: `o_tx_data[DATA_WIDTH-1 -: 8]` carries the 8-bit zero-extended grant index g. The low DATA_WIDTH-8 bits come from the requester's data, and the requester's top byte is discarded.
  - Undefined: the full DATA_WIDTH requester word is forwarded unmodified.

## Test plan
- Single request: `i_req=4'b0100` with data 0x1122334455667788, transmitter idle:
  - `o_ack=4'b0100` in cycle N+1 and `o_tx_request` in N+2;
  - `o_tx_data=0x1122334455667788` (tag off);
  - after `i_tx_done`, `o_done=4'b0100`.
- All four requesting continuously from reset: grant order is 0,1,2,3,0, with exactly one `o_tx_request` per `i_tx_done`.
- Requester 0 held high continuously while requester 2 requests: grants alternate 0,2,0,2.
- `i_tx_busy` forced high for 100 cycles with `i_req=4'b0001`: no `o_ack` during the hold; the grant follows 1 cycle after busy falls.
- Reset asserted in WAIT_DONE, then `i_tx_done` pulsed after release:
  - all outputs are 0 and no `o_done` is produced;
  - the next grant goes to requester 0.
- With `UART_ARB_TAG_EN`, requester 3 sends 0xFFFFFFFFFFFFFFFF: `o_tx_data=0x03FFFFFFFFFFFFFF`.
